// File: rtl/mcycle_if.sv
// mcycle_if: request/response bundle between the Execute stage and the multi-cycle engine
//   master: start, flush, op (0 mul / 1 div), add, mc_long, op1..op3, wa3_in, wa5_in
//   slave:  busy, done, result1 (lo/quotient), result2 (hi/remainder), wa3_out, wa5_out, write_hi
interface mcycle_if #(parameter int WIDTH = 32);
    logic             start, flush, op, add, mc_long;
    logic [WIDTH-1:0] op1, op2, op3;
    logic [3:0]       wa3_in, wa5_in;
    logic             busy, done, write_hi;
    logic [WIDTH-1:0] result1, result2;
    logic [3:0]       wa3_out, wa5_out;
    modport master (
        output start, flush, op, add, mc_long, op1, op2, op3, wa3_in, wa5_in,
        input  busy, done, write_hi, result1, result2, wa3_out, wa5_out
    );
    modport slave (
        input  start, flush, op, add, mc_long, op1, op2, op3, wa3_in, wa5_in,
        output busy, done, write_hi, result1, result2, wa3_out, wa5_out
    );
endinterface

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / restoring divide, one bit per cycle
//   clk_i  clock, rising edge
//   rst_ni asynchronous reset, active low
//   bus    mcycle_if.slave: operands, tags, start/flush in; busy/done, results, tags, write_hi out
module mcycle_unit #(parameter int WIDTH = 32) (
    input logic     clk_i,
    input logic     rst_ni,
    mcycle_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d, step, fin, mul_step, div_step;
    logic [WIDTH-1:0]   opnd_q, opnd_d, acc_q, acc_d;
    logic [WIDTH-1:0]   res1_q, res1_d, res2_q, res2_d;
    logic               div_q, div_d, long_q, long_d, hi_q, hi_d;
    logic [3:0]         wa3c_q, wa3c_d, wa5c_q, wa5c_d, wa3o_q, wa3o_d, wa5o_q, wa5o_d;
    logic [WIDTH:0]     mul_sum, r_sh, r_new;
    logic               ge;
    // p_q holds {partial product, multiplier} for multiply, {remainder, dividend/quotient} for divide
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, p_q[WIDTH-1:1]};
    assign r_sh     = p_q[2*WIDTH-1:WIDTH-1];
    assign ge       = r_sh >= {1'b0, opnd_q};
    assign r_new    = r_sh - (ge ? {1'b0, opnd_q} : '0);
    // a zero divisor always subtracts nothing: quotient all ones, remainder = dividend
    assign div_step = {r_new[WIDTH-1:0], p_q[WIDTH-2:0], ge};
    assign step     = div_q ? div_step : mul_step;
    // accumulate folded into the last step; non-long keeps the raw product high half
    assign fin      = step + {{WIDTH{1'b0}}, acc_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        div_d   = div_q;
        long_d  = long_q;
        wa3c_d  = wa3c_q;
        wa5c_d  = wa5c_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        wa3o_d  = wa3o_q;
        wa5o_d  = wa5o_q;
        hi_d    = hi_q;
        if (bus.flush)
            state_d = IDLE;
        else if (state_q == RUN) begin
            p_d   = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                res1_d  = fin[WIDTH-1:0];
                res2_d  = long_q ? fin[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
                wa3o_d  = wa3c_q;
                wa5o_d  = wa5c_q;
                hi_d    = long_q | div_q;
            end
        end else if (bus.start) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = bus.op;
            long_d  = bus.mc_long & ~bus.op;
            opnd_d  = bus.op ? bus.op2 : bus.op1;
            p_d     = {{WIDTH{1'b0}}, bus.op ? bus.op1 : bus.op2};
            acc_d   = (bus.add & ~bus.op) ? bus.op3 : '0;
            wa3c_d  = bus.wa3_in;
            wa5c_d  = bus.wa5_in;
        end else
            state_d = IDLE;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            div_q   <= 1'b0;
            long_q  <= 1'b0;
            wa3c_q  <= '0;
            wa5c_q  <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
            wa3o_q  <= '0;
            wa5o_q  <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            long_q  <= long_d;
            wa3c_q  <= wa3c_d;
            wa5c_q  <= wa5c_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
            wa3o_q  <= wa3o_d;
            wa5o_q  <= wa5o_d;
            hi_q    <= hi_d;
        end
    end
    // combinational so the launch cycle itself stalls the pipe
    assign bus.busy     = (state_q == RUN) | bus.start;
    assign bus.done     = state_q == DONE;
    assign bus.result1  = res1_q;
    assign bus.result2  = res2_q;
    assign bus.wa3_out  = wa3o_q;
    assign bus.wa5_out  = wa5o_q;
    assign bus.write_hi = hi_q;
endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: scoreboard bench for mcycle_unit with directed vectors
module tb_mcycle_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   errs = 0;
    typedef struct {
        logic [31:0] r1, r2;
        logic [3:0]  t3, t5;
        logic        hi;
        int          due;
    } exp_t;
    exp_t q[$];
    mcycle_if #(.WIDTH(32)) bus ();
    mcycle_unit #(.WIDTH(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic op, input logic add, input logic lng,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [3:0] t3, input logic [3:0] t5,
                         input logic [31:0] e1, input logic [31:0] e2, input logic eh,
                         input bit expect_done);
        bus.op = op; bus.add = add; bus.mc_long = lng;
        bus.op1 = a; bus.op2 = b; bus.op3 = c;
        bus.wa3_in = t3; bus.wa5_in = t5;
        bus.start = 1'b1;
        if (expect_done) q.push_back('{e1, e2, t3, t5, eh, cyc + 33});
    endtask
    task automatic run(input logic op, input logic add, input logic lng,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] t3, input logic [3:0] t5,
                       input logic [31:0] e1, input logic [31:0] e2, input logic eh);
        issue(op, add, lng, a, b, c, t3, t5, e1, e2, eh, 1'b1);
        tick(1);
        bus.start = 1'b0;
        tick(34);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 64'(bus.busy), 64'd0);
        chk({nm, "_done"}, 64'(bus.done), 64'd0);
        chk({nm, "_r1"}, 64'(bus.result1), 64'd0);
        chk({nm, "_r2"}, 64'(bus.result2), 64'd0);
        chk({nm, "_wa3"}, 64'(bus.wa3_out), 64'd0);
        chk({nm, "_wa5"}, 64'(bus.wa5_out), 64'd0);
        chk({nm, "_hi"}, 64'(bus.write_hi), 64'd0);
    endtask
    // monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result1", 64'(bus.result1), 64'(e.r1));
                chk("result2", 64'(bus.result2), 64'(e.r2));
                chk("wa3_out", 64'(bus.wa3_out), 64'(e.t3));
                chk("wa5_out", 64'(bus.wa5_out), 64'(e.t5));
                chk("write_hi", 64'(bus.write_hi), 64'(e.hi));
                chk("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end
    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 1'b0; bus.add = 1'b0; bus.mc_long = 1'b0;
        bus.op1 = '0; bus.op2 = '0; bus.op3 = '0; bus.wa3_in = '0; bus.wa5_in = '0;
        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick(1);
        // MUL 7*6 with full busy/done timing profile
        issue(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 4'd1, 4'd2, 32'd42, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("launch_busy", 64'(bus.busy), 64'd1);
        tick(1);
        bus.start = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 1 || i == 32 || i == 33 || i == 34) begin
                chk($sformatf("busy_t%0d", i), 64'(bus.busy), 64'(i <= 32));
                chk($sformatf("done_t%0d", i), 64'(bus.done), 64'(i == 33));
            end
        end
        tick(1);
        run(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 4'd3, 4'd4, 32'h00000001, 32'hFFFFFFFE, 1'b1);
        run(1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 32'd5, 4'd5, 4'd6, 32'd17, 32'd0, 1'b0);
        run(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'd7, 4'd8, 32'd0, 32'd0, 1'b0);
        run(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd3, 4'd9, 4'd10, 32'h00000001, 32'h00000002, 1'b1);
        run(1'b0, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'd0, 4'd11, 4'd12, 32'd0, 32'd1, 1'b0);
        run(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 32'd0, 4'd13, 4'd14, 32'd14, 32'd2, 1'b1);
        run(1'b1, 1'b1, 1'b1, 32'd100, 32'd7, 32'd9, 4'd15, 4'd1, 32'd14, 32'd2, 1'b1);
        run(1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 4'd2, 4'd3, 32'hFFFFFFFF, 32'd5, 1'b1);
        run(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd16, 32'd0, 4'd4, 4'd5, 32'h0FFFFFFF, 32'd15, 1'b1);
        // Start held (with changing operands) during RUN is ignored
        issue(1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 4'd6, 4'd7, 32'd81, 32'd0, 1'b0, 1'b1);
        tick(1);
        bus.op1 = 32'd1234; bus.op2 = 32'd99; bus.op = 1'b1; bus.wa3_in = 4'd0;
        tick(19);
        bus.start = 1'b0;
        tick(14);
        // back-to-back: new Start in the Done cycle
        issue(1'b0, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0, 4'd8, 4'd9, 32'd143, 32'd0, 1'b0, 1'b1);
        tick(1);
        bus.start = 1'b0;
        tick(32);
        issue(1'b1, 1'b0, 1'b0, 32'd1000, 32'd10, 32'd0, 4'd5, 4'd6, 32'd100, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_done", 64'(bus.done), 64'd1);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        tick(1);
        bus.start = 1'b0;
        tick(34);
        // flush mid-operation: no Done, results hold
        issue(1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 4'd1, 4'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(1);
        bus.start = 1'b0;
        tick(9);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_done", 64'(bus.done), 64'd0);
        tick(30);
        chk("flush_r1_hold", 64'(bus.result1), 64'd100);
        chk("flush_r2_hold", 64'(bus.result2), 64'd0);
        // flush beats start in the same cycle
        issue(1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0, 4'd2, 4'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_busy", 64'(bus.busy), 64'd0);
        tick(40);
        // asynchronous reset mid-operation
        issue(1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'd0, 4'd3, 4'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        tick(1);
        bus.start = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        tick(2);
        rst_n = 1'b1;
        tick(40);
        run(1'b0, 1'b0, 1'b0, 32'd7, 32'd6, 32'd0, 4'd12, 4'd13, 32'd42, 32'd0, 1'b0);
        chk("pending", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
